// File: rtl/muldiv_ctrl_if.sv
// Operation, multiplier, divider and HI/LO status bundle between the
// pipeline / arithmetic units (master) and the HI/LO controller (slave).
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_src1;
    logic [31:0] op_src2;
    logic        op_ready;
    logic        op_cancel;

    logic [1:0]  mul_op;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic [63:0] mul_result;

    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_in_valid;
    logic [63:0] div_result;
    logic        div_out_valid;
    logic        div_out_ready;

    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output op_valid, op_code, op_src1, op_src2, op_cancel,
        output mul_result, div_result, div_out_valid,
        input  op_ready, mul_op, mul_src1, mul_src2,
        input  div_op, dividend, divisor, div_in_valid, div_out_ready,
        input  hi, lo, busy
    );

    modport slave (
        input  op_valid, op_code, op_src1, op_src2, op_cancel,
        input  mul_result, div_result, div_out_valid,
        output op_ready, mul_op, mul_src1, mul_src2,
        output div_op, dividend, divisor, div_in_valid, div_out_ready,
        output hi, lo, busy
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO controller: issues multiplies combinationally, launches a multi-cycle
// divider, and tracks flushes so a cancelled divide never updates HI/LO.
module muldiv_ctrl (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIV_WAIT  = 2'd1,
        DIV_DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_n_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] hi_n_s;
    logic [31:0] lo_n_s;
    logic [1:0]  div_op_r;
    logic [31:0] dividend_r;
    logic [31:0] divisor_r;

    logic        accept_s;
    logic [1:0]  mul_op_s;
    logic        launch_s;
    logic [1:0]  launch_op_s;

    // Acceptance is gated by rst so nothing reaches the units during reset.
    always_comb begin
        accept_s = (state_r == IDLE) && bus.op_valid && !bus.op_cancel && !rst;
    end

    // Operation decode for the accepting cycle.
    always_comb begin
        mul_op_s    = 2'b00;
        launch_s    = 1'b0;
        launch_op_s = 2'b00;
        if (accept_s) begin
            case (bus.op_code)
                OP_MULT:  mul_op_s = 2'b01;
                OP_MULTU: mul_op_s = 2'b10;
                OP_DIV: begin
                    launch_op_s = 2'b01;
                    launch_s    = (bus.op_src2 != 32'd0);
                end
                OP_DIVU: begin
                    launch_op_s = 2'b10;
                    launch_s    = (bus.op_src2 != 32'd0);
                end
                default: begin
                    mul_op_s    = 2'b00;
                    launch_s    = 1'b0;
                    launch_op_s = 2'b00;
                end
            endcase
        end else begin
            mul_op_s    = 2'b00;
            launch_s    = 1'b0;
            launch_op_s = 2'b00;
        end
    end

    // Next-state and HI/LO update logic.
    always_comb begin
        state_n_s = state_r;
        hi_n_s    = hi_r;
        lo_n_s    = lo_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (bus.op_code)
                        OP_MULT, OP_MULTU: begin
                            hi_n_s = bus.mul_result[63:32];
                            lo_n_s = bus.mul_result[31:0];
                        end
                        OP_MTHI: hi_n_s = bus.op_src1;
                        OP_MTLO: lo_n_s = bus.op_src1;
                        OP_DIV, OP_DIVU: begin
                            if (launch_s) begin
                                state_n_s = DIV_WAIT;
                            end else begin
                                state_n_s = IDLE;
                            end
                        end
                        default: state_n_s = IDLE;
                    endcase
                end else begin
                    state_n_s = IDLE;
                end
            end
            DIV_WAIT: begin
                // A flush with the result in the same cycle drops the result.
                if (bus.op_cancel) begin
                    if (bus.div_out_valid) begin
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = DIV_DRAIN;
                    end
                end else if (bus.div_out_valid) begin
                    hi_n_s    = bus.div_result[63:32];
                    lo_n_s    = bus.div_result[31:0];
                    state_n_s = IDLE;
                end else begin
                    state_n_s = DIV_WAIT;
                end
            end
            DIV_DRAIN: begin
                if (bus.div_out_valid) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = DIV_DRAIN;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // State and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state_r <= state_n_s;
            hi_r    <= hi_n_s;
            lo_r    <= lo_n_s;
        end
    end

    // Divider operands captured at launch and held until the result returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_op_r   <= 2'b00;
            dividend_r <= 32'd0;
            divisor_r  <= 32'd0;
        end else if (launch_s) begin
            div_op_r   <= launch_op_s;
            dividend_r <= bus.op_src1;
            divisor_r  <= bus.op_src2;
        end else begin
            div_op_r   <= div_op_r;
            dividend_r <= dividend_r;
            divisor_r  <= divisor_r;
        end
    end

    assign bus.op_ready      = (state_r == IDLE);
    assign bus.mul_op        = mul_op_s;
    assign bus.mul_src1      = (mul_op_s != 2'b00) ? bus.op_src1 : 32'd0;
    assign bus.mul_src2      = (mul_op_s != 2'b00) ? bus.op_src2 : 32'd0;
    assign bus.div_in_valid  = launch_s;
    assign bus.div_op        = launch_s ? launch_op_s : div_op_r;
    assign bus.dividend      = launch_s ? bus.op_src1 : dividend_r;
    assign bus.divisor       = launch_s ? bus.op_src2 : divisor_r;
    assign bus.div_out_ready = (state_r != IDLE);
    assign bus.busy          = (state_r != IDLE);
    assign bus.hi            = hi_r;
    assign bus.lo            = lo_r;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a table of single-cycle ops followed by
// hand-written divide, flush and reset sequences.
module tb_muldiv_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        cancel;
        logic [2:0]  code;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [63:0] mres;
        logic [1:0]  exp_mul_op;
        logic        exp_launch;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] code, input logic [31:0] s1, input logic [31:0] s2);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_src1  = s1;
        bus.op_src2  = s2;
    endtask

    initial begin
        int errs;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{1'b1, 1'b0, 3'd1, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 2'b10, 1'b0, 32'h00000001, 32'h00000000};
        vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h12345678, 32'd0, 64'hDEADBEEF_DEADBEEF, 2'b00, 1'b0, 32'h12345678, 32'h00000000};
        vecs[3]  = '{1'b1, 1'b0, 3'd5, 32'h9ABCDEF0, 32'd0, 64'hDEADBEEF_DEADBEEF, 2'b00, 1'b0, 32'h12345678, 32'h9ABCDEF0};
        vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'd5, 32'd0, 64'hDEADBEEF_DEADBEEF, 2'b00, 1'b0, 32'h12345678, 32'h9ABCDEF0};
        vecs[5]  = '{1'b1, 1'b0, 3'd3, 32'd7, 32'd0, 64'hDEADBEEF_DEADBEEF, 2'b00, 1'b0, 32'h12345678, 32'h9ABCDEF0};
        vecs[6]  = '{1'b1, 1'b0, 3'd6, 32'h11111111, 32'd2, 64'hDEADBEEF_DEADBEEF, 2'b00, 1'b0, 32'h12345678, 32'h9ABCDEF0};
        vecs[7]  = '{1'b1, 1'b0, 3'd7, 32'h22222222, 32'd2, 64'hDEADBEEF_DEADBEEF, 2'b00, 1'b0, 32'h12345678, 32'h9ABCDEF0};
        vecs[8]  = '{1'b1, 1'b1, 3'd0, 32'd3, 32'd3, 64'hDEADBEEF_DEADBEEF, 2'b00, 1'b0, 32'h12345678, 32'h9ABCDEF0};
        vecs[9]  = '{1'b0, 1'b0, 3'd4, 32'h33333333, 32'd0, 64'hDEADBEEF_DEADBEEF, 2'b00, 1'b0, 32'h12345678, 32'h9ABCDEF0};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 32'd7, 32'd6, 64'h00000000_0000002A, 2'b01, 1'b0, 32'h00000000, 32'h0000002A};

        rst               = 1'b1;
        bus.op_valid      = 1'b0;
        bus.op_code       = 3'd0;
        bus.op_src1       = 32'd0;
        bus.op_src2       = 32'd0;
        bus.op_cancel     = 1'b0;
        bus.mul_result    = 64'd0;
        bus.div_result    = 64'd0;
        bus.div_out_valid = 1'b0;
        repeat (3) tick();
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_div_out_ready", 32'(bus.div_out_ready), 32'd0);
        chk("reset_div_in_valid", 32'(bus.div_in_valid), 32'd0);
        chk("reset_mul_op", 32'(bus.mul_op), 32'd0);
        chk("reset_div_op", 32'(bus.div_op), 32'd0);
        chk("reset_dividend", bus.dividend, 32'd0);
        chk("reset_divisor", bus.divisor, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            bus.op_valid   = vecs[i].valid;
            bus.op_cancel  = vecs[i].cancel;
            bus.op_code    = vecs[i].code;
            bus.op_src1    = vecs[i].src1;
            bus.op_src2    = vecs[i].src2;
            bus.mul_result = vecs[i].mres;
            @(negedge clk);
            chk($sformatf("vec%0d_op_ready", i), 32'(bus.op_ready), 32'd1);
            chk($sformatf("vec%0d_mul_op", i), 32'(bus.mul_op), 32'(vecs[i].exp_mul_op));
            chk($sformatf("vec%0d_div_in_valid", i), 32'(bus.div_in_valid), 32'(vecs[i].exp_launch));
            if (vecs[i].exp_mul_op != 2'b00) begin
                chk($sformatf("vec%0d_mul_src1", i), bus.mul_src1, vecs[i].src1);
                chk($sformatf("vec%0d_mul_src2", i), bus.mul_src2, vecs[i].src2);
            end
            tick();
            bus.op_valid  = 1'b0;
            bus.op_cancel = 1'b0;
            chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].exp_lo);
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
        end

        // DIVU 100/7 with a stray MTHI offered while the divide is in flight.
        offer(3'd3, 32'd100, 32'd7);
        @(negedge clk);
        chk("divu_launch", 32'(bus.div_in_valid), 32'd1);
        chk("divu_launch_op", 32'(bus.div_op), 32'd2);
        chk("divu_launch_dividend", bus.dividend, 32'd100);
        tick();
        offer(3'd4, 32'h00000BAD, 32'd0);
        chk("divu_busy", 32'(bus.busy), 32'd1);
        chk("divu_single_pulse", 32'(bus.div_in_valid), 32'd0);
        chk("divu_op_ready_low", 32'(bus.op_ready), 32'd0);
        chk("divu_out_ready", 32'(bus.div_out_ready), 32'd1);
        chk("divu_held_divisor", bus.divisor, 32'd7);
        chk("divu_held_op", 32'(bus.div_op), 32'd2);
        errs = 0;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.div_in_valid !== 1'b0 ||
                bus.dividend !== 32'd100 || bus.divisor !== 32'd7 || bus.hi !== 32'd0)
                errs++;
            tick();
        end
        chk("divu_wait_stable", 32'(errs), 32'd0);
        bus.op_valid      = 1'b0;
        bus.div_out_valid = 1'b1;
        bus.div_result    = {32'd2, 32'd14};
        tick();
        bus.div_out_valid = 1'b0;
        chk("divu_hi", bus.hi, 32'd2);
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_busy_clear", 32'(bus.busy), 32'd0);
        chk("divu_op_ready", 32'(bus.op_ready), 32'd1);

        // DIV 86/9 flushed in the third wait cycle; result arrives later.
        offer(3'd2, 32'd86, 32'd9);
        tick();
        bus.op_valid = 1'b0;
        tick();
        tick();
        bus.op_cancel = 1'b1;
        tick();
        bus.op_cancel = 1'b0;
        chk("drain_busy", 32'(bus.busy), 32'd1);
        chk("drain_op_ready", 32'(bus.op_ready), 32'd0);
        repeat (4) tick();
        bus.div_out_valid = 1'b1;
        bus.div_result    = {32'd5, 32'd9};
        @(negedge clk);
        chk("drain_out_ready", 32'(bus.div_out_ready), 32'd1);
        tick();
        bus.div_out_valid = 1'b0;
        chk("drain_hi", bus.hi, 32'd2);
        chk("drain_lo", bus.lo, 32'd14);
        chk("drain_busy_clear", 32'(bus.busy), 32'd0);
        chk("drain_op_ready_back", 32'(bus.op_ready), 32'd1);

        // Flush coinciding with the result: result dropped, straight to IDLE.
        offer(3'd3, 32'd9, 32'd4);
        tick();
        bus.op_valid      = 1'b0;
        bus.op_cancel     = 1'b1;
        bus.div_out_valid = 1'b1;
        bus.div_result    = {32'd1, 32'd2};
        tick();
        bus.op_cancel     = 1'b0;
        bus.div_out_valid = 1'b0;
        chk("cancel_valid_busy", 32'(bus.busy), 32'd0);
        chk("cancel_valid_hi", bus.hi, 32'd2);
        chk("cancel_valid_lo", bus.lo, 32'd14);

        // Reset in the middle of a divide; the late result must be ignored.
        offer(3'd2, 32'd86, 32'd9);
        tick();
        bus.op_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
        chk("rst_div_out_ready", 32'(bus.div_out_ready), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_dividend", bus.dividend, 32'd0);
        chk("rst_divisor", bus.divisor, 32'd0);
        tick();
        bus.div_out_valid = 1'b1;
        bus.div_result    = {32'd5, 32'd9};
        tick();
        bus.div_out_valid = 1'b0;
        chk("late_hi", bus.hi, 32'd0);
        chk("late_lo", bus.lo, 32'd0);
        chk("late_busy", 32'(bus.busy), 32'd0);
        chk("late_op_ready", 32'(bus.op_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
